// File: rtl/carbon_fabric_arb2.sv
// ----------------------------------------------------------------------------
// carbon_fabric_arb2
//
// Purpose:
//   Two-master to one-slave fabric arbiter with a single outstanding
//   transaction. Typically shares one slave (e.g. the boot ROM) between the
//   CPU fetch port (m0) and a DMA/debug port (m1). Grants are round-robin,
//   the request and response are both registered, and an optional response
//   watchdog turns a hung slave into an error response for the master. If the
//   watchdog fires, the slave's late response is drained and thrown away
//   before any new request is granted.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mN_req_valid_i / ready_o     master N request handshake (N = 0, 1)
//   mN_req_addr/op/size/attr/id/wdata/wstrb_i   master N request fields
//   mN_rsp_valid_o / ready_i     master N response handshake
//   mN_rsp_rdata/code/id_o       master N response fields
//   s_req_valid_o / ready_i      slave request handshake
//   s_req_addr/op/size/attr/id/wdata/wstrb_o    slave request fields
//   s_rsp_valid_i / ready_o      slave response handshake
//   s_rsp_rdata/code/id_i        slave response fields
//   timeout_evt_o                one-cycle pulse on watchdog expiry
// ----------------------------------------------------------------------------
module carbon_fabric_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int OP_W = 2,
  parameter int SIZE_W = 2,
  parameter int ATTR_W = 4,
  parameter int ID_W = 4,
  parameter int CODE_W = 2,
  parameter int TIMEOUT_CYCLES = 0,
  parameter logic [CODE_W-1:0] TIMEOUT_CODE = 2'h3
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_req_valid_i,
  output logic              m0_req_ready_o,
  input  logic [ADDR_W-1:0] m0_req_addr_i,
  input  logic [OP_W-1:0]   m0_req_op_i,
  input  logic [SIZE_W-1:0] m0_req_size_i,
  input  logic [ATTR_W-1:0] m0_req_attr_i,
  input  logic [ID_W-1:0]   m0_req_id_i,
  input  logic [DATA_W-1:0] m0_req_wdata_i,
  input  logic [STRB_W-1:0] m0_req_wstrb_i,
  output logic              m0_rsp_valid_o,
  input  logic              m0_rsp_ready_i,
  output logic [DATA_W-1:0] m0_rsp_rdata_o,
  output logic [CODE_W-1:0] m0_rsp_code_o,
  output logic [ID_W-1:0]   m0_rsp_id_o,

  input  logic              m1_req_valid_i,
  output logic              m1_req_ready_o,
  input  logic [ADDR_W-1:0] m1_req_addr_i,
  input  logic [OP_W-1:0]   m1_req_op_i,
  input  logic [SIZE_W-1:0] m1_req_size_i,
  input  logic [ATTR_W-1:0] m1_req_attr_i,
  input  logic [ID_W-1:0]   m1_req_id_i,
  input  logic [DATA_W-1:0] m1_req_wdata_i,
  input  logic [STRB_W-1:0] m1_req_wstrb_i,
  output logic              m1_rsp_valid_o,
  input  logic              m1_rsp_ready_i,
  output logic [DATA_W-1:0] m1_rsp_rdata_o,
  output logic [CODE_W-1:0] m1_rsp_code_o,
  output logic [ID_W-1:0]   m1_rsp_id_o,

  output logic              s_req_valid_o,
  input  logic              s_req_ready_i,
  output logic [ADDR_W-1:0] s_req_addr_o,
  output logic [OP_W-1:0]   s_req_op_o,
  output logic [SIZE_W-1:0] s_req_size_o,
  output logic [ATTR_W-1:0] s_req_attr_o,
  output logic [ID_W-1:0]   s_req_id_o,
  output logic [DATA_W-1:0] s_req_wdata_o,
  output logic [STRB_W-1:0] s_req_wstrb_o,
  input  logic              s_rsp_valid_i,
  output logic              s_rsp_ready_o,
  input  logic [DATA_W-1:0] s_rsp_rdata_i,
  input  logic [CODE_W-1:0] s_rsp_code_i,
  input  logic [ID_W-1:0]   s_rsp_id_i,

  output logic              timeout_evt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;

  // Timer is wide enough to hold TIMEOUT_CYCLES and saturates at all-ones.
  localparam int TMR_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX = '1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]        state_q, state_d;
  logic              rr_q, rr_d;
  logic              drain_q, drain_d;
  logic              grant_q, grant_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [ATTR_W-1:0] attr_q, attr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [ID_W-1:0]   rid_q, rid_d;

  logic              canGrant;
  logic              anyValid;
  logic              winner;
  logic              fire;
  logic              expire;
  logic              rspReady;

  // Arbitration: a lone requester always wins; with both valid rr_q picks.
  // Grants are only offered in IDLE and never while a late response is
  // still owed by the slave.
  always_comb begin
    canGrant = (state_q == IDLE) && !drain_q;
    anyValid = m0_req_valid_i || m1_req_valid_i;
    if (m0_req_valid_i && m1_req_valid_i) begin
      winner = rr_q;
    end else begin
      winner = m1_req_valid_i;
    end
    fire = canGrant && anyValid;
    m0_req_ready_o = fire && !winner;
    m1_req_ready_o = fire && winner;
  end

  // A slave response in the expiry cycle takes priority over the timeout.
  assign expire = WDOG_EN && (state_q == WAIT) && (tmr_q == TMR_LAST) && !s_rsp_valid_i;
  assign timeout_evt_o = expire;
  assign rspReady = grant_q ? m1_rsp_ready_i : m0_rsp_ready_i;

  // Next-state logic for the FSM, captured request/response fields,
  // round-robin pointer, watchdog timer and drain flag.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    drain_d = drain_q;
    grant_d = grant_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    op_d    = op_q;
    size_d  = size_q;
    attr_d  = attr_q;
    id_d    = id_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    code_d  = code_q;
    rid_d   = rid_q;

    // The first slave response seen while draining is the orphan of a
    // timed-out transaction; accept it and drop it on the floor.
    if (drain_q && s_rsp_valid_i) begin
      drain_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (fire) begin
          grant_d = winner;
          addr_d  = winner ? m1_req_addr_i  : m0_req_addr_i;
          op_d    = winner ? m1_req_op_i    : m0_req_op_i;
          size_d  = winner ? m1_req_size_i  : m0_req_size_i;
          attr_d  = winner ? m1_req_attr_i  : m0_req_attr_i;
          id_d    = winner ? m1_req_id_i    : m0_req_id_i;
          wdata_d = winner ? m1_req_wdata_i : m0_req_wdata_i;
          wstrb_d = winner ? m1_req_wstrb_i : m0_req_wstrb_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (s_req_ready_i) begin
          tmr_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (s_rsp_valid_i) begin
          rdata_d = s_rsp_rdata_i;
          code_d  = s_rsp_code_i;
          rid_d   = s_rsp_id_i;
          state_d = RSP;
        end else begin
          if (tmr_q != TMR_MAX) begin
            tmr_d = tmr_q + TMR_W'(1);
          end
          if (expire) begin
            rdata_d = '0;
            code_d  = TIMEOUT_CODE;
            rid_d   = id_q;
            drain_d = 1'b1;
            state_d = RSP;
          end
        end
      end
      default: begin
        if (rspReady) begin
          rr_d    = ~grant_q;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      drain_q <= 1'b0;
      grant_q <= 1'b0;
      tmr_q   <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      size_q  <= '0;
      attr_q  <= '0;
      id_q    <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      code_q  <= '0;
      rid_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      drain_q <= drain_d;
      grant_q <= grant_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      size_q  <= size_d;
      attr_q  <= attr_d;
      id_q    <= id_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
      rid_q   <= rid_d;
    end
  end

  assign s_req_valid_o = (state_q == REQ);
  assign s_req_addr_o  = addr_q;
  assign s_req_op_o    = op_q;
  assign s_req_size_o  = size_q;
  assign s_req_attr_o  = attr_q;
  assign s_req_id_o    = id_q;
  assign s_req_wdata_o = wdata_q;
  assign s_req_wstrb_o = wstrb_q;
  assign s_rsp_ready_o = (state_q == WAIT) || drain_q;

  // Response fields are broadcast; only the granted master sees valid.
  assign m0_rsp_valid_o = (state_q == RSP) && !grant_q;
  assign m1_rsp_valid_o = (state_q == RSP) && grant_q;
  assign m0_rsp_rdata_o = rdata_q;
  assign m0_rsp_code_o  = code_q;
  assign m0_rsp_id_o    = rid_q;
  assign m1_rsp_rdata_o = rdata_q;
  assign m1_rsp_code_o  = code_q;
  assign m1_rsp_id_o    = rid_q;

endmodule

// File: tb/tb_carbon_fabric_arb2.sv
// ----------------------------------------------------------------------------
// tb_carbon_fabric_arb2
//
// Self-checking bench for carbon_fabric_arb2 built with an 8-cycle watchdog.
// A behavioural slave models a byte-image ROM (byte at address a holds a[7:0])
// that answers reads with OK and writes with ACCESS_FAULT after a
// programmable number of WAIT cycles. Master stimulus and the slave are
// driven on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_carbon_fabric_arb2;

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] CODE_OK    = 2'd0;
  localparam logic [1:0] CODE_FAULT = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        m0_req_valid = 1'b0, m0_req_ready;
  logic [31:0] m0_req_addr = '0, m0_req_wdata = '0;
  logic [1:0]  m0_req_op = '0, m0_req_size = 2'd2;
  logic [3:0]  m0_req_attr = '0, m0_req_id = '0, m0_req_wstrb = '0;
  logic        m0_rsp_valid, m0_rsp_ready = 1'b1;
  logic [31:0] m0_rsp_rdata;
  logic [1:0]  m0_rsp_code;
  logic [3:0]  m0_rsp_id;

  logic        m1_req_valid = 1'b0, m1_req_ready;
  logic [31:0] m1_req_addr = '0, m1_req_wdata = '0;
  logic [1:0]  m1_req_op = '0, m1_req_size = 2'd2;
  logic [3:0]  m1_req_attr = '0, m1_req_id = '0, m1_req_wstrb = '0;
  logic        m1_rsp_valid, m1_rsp_ready = 1'b1;
  logic [31:0] m1_rsp_rdata;
  logic [1:0]  m1_rsp_code;
  logic [3:0]  m1_rsp_id;

  logic        s_req_valid, s_req_ready = 1'b1;
  logic [31:0] s_req_addr, s_req_wdata;
  logic [1:0]  s_req_op, s_req_size;
  logic [3:0]  s_req_attr, s_req_id, s_req_wstrb;
  logic        s_rsp_valid = 1'b0, s_rsp_ready;
  logic [31:0] s_rsp_rdata = '0;
  logic [1:0]  s_rsp_code = '0;
  logic [3:0]  s_rsp_id = '0;
  logic        timeout_evt;

  int checkCount = 0;
  int passCount = 0;

  int          slvDelay = 0;
  int          slvWait = 0;
  logic        slvPend = 1'b0, hsReq = 1'b0, hsRsp = 1'b0;
  logic [31:0] slvAddr = '0;
  logic [1:0]  slvOp = '0;
  logic [3:0]  slvId = '0;

  carbon_fabric_arb2 #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_valid_i(m0_req_valid), .m0_req_ready_o(m0_req_ready),
    .m0_req_addr_i(m0_req_addr), .m0_req_op_i(m0_req_op), .m0_req_size_i(m0_req_size),
    .m0_req_attr_i(m0_req_attr), .m0_req_id_i(m0_req_id), .m0_req_wdata_i(m0_req_wdata),
    .m0_req_wstrb_i(m0_req_wstrb),
    .m0_rsp_valid_o(m0_rsp_valid), .m0_rsp_ready_i(m0_rsp_ready),
    .m0_rsp_rdata_o(m0_rsp_rdata), .m0_rsp_code_o(m0_rsp_code), .m0_rsp_id_o(m0_rsp_id),
    .m1_req_valid_i(m1_req_valid), .m1_req_ready_o(m1_req_ready),
    .m1_req_addr_i(m1_req_addr), .m1_req_op_i(m1_req_op), .m1_req_size_i(m1_req_size),
    .m1_req_attr_i(m1_req_attr), .m1_req_id_i(m1_req_id), .m1_req_wdata_i(m1_req_wdata),
    .m1_req_wstrb_i(m1_req_wstrb),
    .m1_rsp_valid_o(m1_rsp_valid), .m1_rsp_ready_i(m1_rsp_ready),
    .m1_rsp_rdata_o(m1_rsp_rdata), .m1_rsp_code_o(m1_rsp_code), .m1_rsp_id_o(m1_rsp_id),
    .s_req_valid_o(s_req_valid), .s_req_ready_i(s_req_ready),
    .s_req_addr_o(s_req_addr), .s_req_op_o(s_req_op), .s_req_size_o(s_req_size),
    .s_req_attr_o(s_req_attr), .s_req_id_o(s_req_id), .s_req_wdata_o(s_req_wdata),
    .s_req_wstrb_o(s_req_wstrb),
    .s_rsp_valid_i(s_rsp_valid), .s_rsp_ready_o(s_rsp_ready),
    .s_rsp_rdata_i(s_rsp_rdata), .s_rsp_code_i(s_rsp_code), .s_rsp_id_i(s_rsp_id),
    .timeout_evt_o(timeout_evt)
  );

  always #5 clk = ~clk;

  // Byte-image ROM word: byte at address a holds a[7:0].
  function automatic logic [31:0] romWord(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Behavioural slave. Handshakes that happened on the previous rising edge
  // are recognised from the values recorded at the previous falling edge.
  // A request accepted in REQ gets its response slvDelay WAIT cycles later.
  always @(negedge clk) begin
    if (rst) begin
      s_rsp_valid = 1'b0;
      slvPend = 1'b0;
      hsReq = 1'b0;
      hsRsp = 1'b0;
    end else begin
      if (hsRsp) s_rsp_valid = 1'b0;
      if (hsReq) begin
        slvPend = 1'b1;
        slvWait = slvDelay;
      end
      if (slvPend && !s_rsp_valid) begin
        if (slvWait == 0) begin
          s_rsp_valid = 1'b1;
          s_rsp_id = slvId;
          if (slvOp == OP_WRITE) begin
            s_rsp_code = CODE_FAULT;
            s_rsp_rdata = '0;
          end else begin
            s_rsp_code = CODE_OK;
            s_rsp_rdata = romWord(slvAddr);
          end
          slvPend = 1'b0;
        end else begin
          slvWait = slvWait - 1;
        end
      end
      hsReq = s_req_valid && s_req_ready;
      if (hsReq) begin
        slvAddr = s_req_addr;
        slvOp = s_req_op;
        slvId = s_req_id;
      end
      hsRsp = s_rsp_valid && s_rsp_ready;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic v, input logic [31:0] a,
                               input logic [1:0] op, input logic [3:0] id, input logic [3:0] strb);
    if (m == 0) begin
      m0_req_valid = v; m0_req_addr = a; m0_req_op = op; m0_req_id = id;
      m0_req_wstrb = strb; m0_req_wdata = 32'hA5A50000 | a;
    end else begin
      m1_req_valid = v; m1_req_addr = a; m1_req_op = op; m1_req_id = id;
      m1_req_wstrb = strb; m1_req_wdata = 32'h5A5A0000 | a;
    end
  endtask

  // One complete transaction on master m. lat is the number of rising edges
  // from the request fire to the first cycle with rsp_valid.
  task automatic runTransaction(input int m, input logic [31:0] a, input logic [1:0] op,
                                input logic [3:0] id, input logic [3:0] strb,
                                output logic [31:0] rd, output logic [1:0] cd, output logic [3:0] ri,
                                output int lat, output int evts, output int other);
    int fireC;
    bit done;
    fireC = -1; done = 0; lat = -1; evts = 0; other = 0; rd = '0; cd = '0; ri = '0;
    @(negedge clk);
    applyStimulus(m, 1'b1, a, op, id, strb);
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (timeout_evt) evts++;
      if (fireC < 0 && ((m == 0) ? m0_req_ready : m1_req_ready)) fireC = c;
      if ((m == 0) ? m0_rsp_valid : m1_rsp_valid) begin
        done = 1;
        lat = c - fireC;
        rd = (m == 0) ? m0_rsp_rdata : m1_rsp_rdata;
        cd = (m == 0) ? m0_rsp_code : m1_rsp_code;
        ri = (m == 0) ? m0_rsp_id : m1_rsp_id;
      end
      if ((m == 0) ? m1_rsp_valid : m0_rsp_valid) other++;
      @(negedge clk);
      if (fireC >= 0) begin
        if (m == 0) m0_req_valid = 1'b0; else m1_req_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] hang");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  cd;
    logic [3:0]  ri;
    int lat, evts, other;
    int grantSeq[4], rspMst[4], nG, nR;
    logic [3:0]  rspId[4];
    logic [31:0] rspData[4];
    int evtCnt, tEvt, m1Fire, m0RspCnt, m1RspCnt;
    bit got0, seen;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_s_req_valid", s_req_valid, 0);
    checkOutput("rst_s_rsp_ready", s_rsp_ready, 0);
    checkOutput("rst_m_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
    checkOutput("rst_s_req_addr", s_req_addr, 0);
    checkOutput("rst_m0_rsp_rdata", m0_rsp_rdata, 0);
    checkOutput("rst_timeout_evt", timeout_evt, 0);
    checkOutput("rst_state", dut.state_q, 0);
    @(negedge clk);
    rst = 1'b0;

    // m0 read at 0x10: fire cycle 0, REQ 1, slave answers in WAIT cycle 2,
    // rsp_valid in cycle 3 (four cycles counting both ends).
    runTransaction(0, 32'h10, OP_READ, 4'h1, 4'h0, rd, cd, ri, lat, evts, other);
    checkOutput("rd0_rdata", rd, 32'h13121110);
    checkOutput("rd0_code", cd, CODE_OK);
    checkOutput("rd0_id", ri, 4'h1);
    checkOutput("rd0_latency", lat, 3);
    checkOutput("rd0_m1_quiet", other, 0);
    checkOutput("rd0_rr", dut.rr_q, 1);

    // m1 write to ROM: fault passes through, rr flips back to m0
    runTransaction(1, 32'h80, OP_WRITE, 4'h5, 4'hF, rd, cd, ri, lat, evts, other);
    checkOutput("wr1_code", cd, CODE_FAULT);
    checkOutput("wr1_rdata", rd, 0);
    checkOutput("wr1_id", ri, 4'h5);
    checkOutput("wr1_m0_quiet", other, 0);
    checkOutput("wr1_rr", dut.rr_q, 0);

    // Both masters request continuously: grants alternate m0,m1,m0,m1
    nG = 0; nR = 0;
    @(negedge clk);
    applyStimulus(0, 1'b1, 32'h20, OP_READ, 4'h1, 4'h0);
    applyStimulus(1, 1'b1, 32'h40, OP_READ, 4'h2, 4'h0);
    for (int c = 0; c < 100 && nR < 4; c++) begin
      #1;
      if (m0_req_valid && m0_req_ready && nG < 4) begin grantSeq[nG] = 0; nG++; end
      if (m1_req_valid && m1_req_ready && nG < 4) begin grantSeq[nG] = 1; nG++; end
      if (m0_rsp_valid && nR < 4) begin
        rspMst[nR] = 0; rspId[nR] = m0_rsp_id; rspData[nR] = m0_rsp_rdata; nR++;
      end
      if (m1_rsp_valid && nR < 4) begin
        rspMst[nR] = 1; rspId[nR] = m1_rsp_id; rspData[nR] = m1_rsp_rdata; nR++;
      end
      @(negedge clk);
      if (nG >= 4) begin
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
      end
    end
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    checkOutput("rr_rsp_count", nR, 4);
    for (int i = 0; i < nR; i++) begin
      checkOutput($sformatf("rr_grant%0d", i), grantSeq[i], i % 2);
      checkOutput($sformatf("rr_rspmst%0d", i), rspMst[i], i % 2);
      checkOutput($sformatf("rr_id%0d", i), rspId[i], (i % 2) ? 4'h2 : 4'h1);
      checkOutput($sformatf("rr_data%0d", i), rspData[i],
                  (i % 2) ? 32'h43424140 : 32'h23222120);
    end

    // Watchdog: slave answers 20 WAIT cycles late. WAIT spans cycles 2..9,
    // so expiry is cycle 9, m0 response in 10. m1 asks from cycle 11 but is
    // held off until the late response (cycle 22) is drained; granted in 23.
    slvDelay = 20;
    evtCnt = 0; tEvt = -1; m1Fire = -1; m0RspCnt = 0; m1RspCnt = 0; got0 = 0;
    @(negedge clk);
    applyStimulus(0, 1'b1, 32'h30, OP_READ, 4'h7, 4'h0);
    for (int c = 0; c < 80 && m1Fire < 0; c++) begin
      #1;
      if (c == 0) checkOutput("to_m0_fire", m0_req_ready, 1);
      if (timeout_evt) begin evtCnt++; tEvt = c; slvDelay = 0; end
      if (m0_rsp_valid) begin
        got0 = 1; m0RspCnt++; rd = m0_rsp_rdata; cd = m0_rsp_code; ri = m0_rsp_id;
      end
      if (m1_rsp_valid) m1RspCnt++;
      if (c == 15) checkOutput("to_drain_set", dut.drain_q, 1);
      if (c == 21) checkOutput("to_m1_stalled", m1_req_ready, 0);
      if (m1_req_valid && m1_req_ready) m1Fire = c;
      @(negedge clk);
      if (c == 0) m0_req_valid = 1'b0;
      if (got0 && !m1_req_valid && m1Fire < 0) applyStimulus(1, 1'b1, 32'h44, OP_READ, 4'h9, 4'h0);
    end
    m1_req_valid = 1'b0;
    checkOutput("to_evt_count", evtCnt, 1);
    checkOutput("to_evt_cycle", tEvt, 9);
    checkOutput("to_code", cd, 2'h3);
    checkOutput("to_rdata", rd, 0);
    checkOutput("to_id", ri, 4'h7);
    checkOutput("to_m0_rsp_count", m0RspCnt, 1);
    checkOutput("to_drained_quiet", m1RspCnt, 0);
    checkOutput("to_m1_fire_cycle", m1Fire, 23);
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (m1_rsp_valid) begin
        seen = 1; rd = m1_rsp_rdata; ri = m1_rsp_id; cd = m1_rsp_code;
      end
      @(negedge clk);
    end
    checkOutput("to_m1_rsp_seen", seen, 1);
    checkOutput("to_m1_rdata", rd, 32'h47464544);
    checkOutput("to_m1_id", ri, 4'h9);
    checkOutput("to_m1_code", cd, CODE_OK);

    // Response in the expiry cycle (WAIT cycle 9) wins over the watchdog
    slvDelay = 7;
    runTransaction(0, 32'h50, OP_READ, 4'h3, 4'h0, rd, cd, ri, lat, evts, other);
    checkOutput("tie_evts", evts, 0);
    checkOutput("tie_rdata", rd, 32'h53525150);
    checkOutput("tie_code", cd, CODE_OK);
    checkOutput("tie_id", ri, 4'h3);
    checkOutput("tie_latency", lat, 10);
    checkOutput("tie_drain", dut.drain_q, 0);
    slvDelay = 0;

    // Reset while in REQ
    @(negedge clk);
    applyStimulus(0, 1'b1, 32'h60, OP_READ, 4'hA, 4'h0);
    @(negedge clk);
    m0_req_valid = 1'b0;
    #1;
    checkOutput("rreq_in_req", s_req_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rreq_s_req_valid", s_req_valid, 0);
    checkOutput("rreq_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
    checkOutput("rreq_state", dut.state_q, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset while in RSP (master holds off rsp_ready)
    m0_rsp_ready = 1'b0;
    seen = 0;
    @(negedge clk);
    applyStimulus(0, 1'b1, 32'h70, OP_READ, 4'hB, 4'h0);
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (m0_rsp_valid) seen = 1;
      @(negedge clk);
      m0_req_valid = 1'b0;
    end
    checkOutput("rrsp_reached", seen, 1);
    rst = 1'b1;
    m0_rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rrsp_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
    checkOutput("rrsp_state", dut.state_q, 0);
    @(negedge clk);
    rst = 1'b0;

    // First transaction after reset completes normally
    runTransaction(1, 32'h74, OP_READ, 4'hC, 4'h0, rd, cd, ri, lat, evts, other);
    checkOutput("post_rdata", rd, 32'h77767574);
    checkOutput("post_code", cd, CODE_OK);
    checkOutput("post_id", ri, 4'hC);
    checkOutput("post_latency", lat, 3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/carbon_fabric_arb2.md
Name: carbon_fabric_arb2

Overview:
- Two-master to one-slave fabric arbiter with a single outstanding transaction.
- Shares one fabric slave, e.g. the boot ROM, between two requesters (CPU fetch port and a DMA/debug port).
- Round-robin grant, registered request and response stages, and a response watchdog that converts a hung slave into an error response.
- After a watchdog expiry, the late slave response is drained and discarded.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STRB_W, DATA_W/8, write strobe width.
- OP_W, 2, req_op width; SIZE_W, 2, req_size width; ATTR_W, 4, req_attr width.
- ID_W, 4, transaction id width.
- CODE_W, 2, rsp_code width.
- TIMEOUT_CYCLES, 0, watchdog limit in cycles in WAIT state; 0 disables the watchdog.
- TIMEOUT_CODE, 2'h3, rsp_code returned on watchdog expiry.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mN_req_valid/mN_req_ready  in/out  1  master N request handshake (N=0,1)
- mN_req_addr/op/size/attr/id/wdata/wstrb  in  ADDR_W/OP_W/SIZE_W/ATTR_W/ID_W/DATA_W/STRB_W  master N request fields
- mN_rsp_valid/mN_rsp_ready  out/in  1  master N response handshake
- mN_rsp_rdata/code/id  out  DATA_W/CODE_W/ID_W  master N response fields
- s_req_valid/s_req_ready  out/in  1  slave request handshake
- s_req_addr/op/size/attr/id/wdata/wstrb  out  as above  slave request fields
- s_rsp_valid/s_rsp_ready  in/out  1  slave response handshake
- s_rsp_rdata/code/id  in  DATA_W/CODE_W/ID_W  slave response fields
- timeout_evt  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset state: FSM IDLE; rr_q=0; drain_q=0; tmr=0. All valid/ready outputs 0, all data outputs 0, timeout_evt=0.
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE, ready generation: mN_req_ready is combinational. Only the winner sees ready=1, and only when state=IDLE and drain_q=0.
- IDLE, arbitration: if both masters are valid, the winner is rr_q. If only one is valid, that master wins.
- IDLE, on a fire: capture all request fields and grant_q, then go to REQ.
- REQ: s_req_valid=1 with the registered fields, held stable until s_req_ready=1. Then go to WAIT with tmr=0.
- WAIT: s_rsp_ready=1. On s_rsp_valid, capture rdata, code and id, then go to RSP.
- WAIT, watchdog: otherwise tmr increments. If TIMEOUT_CYCLES≠0 and tmr==TIMEOUT_CYCLES-1 with no s_rsp_valid that cycle:
  - load rdata=0, code=TIMEOUT_CODE, id=the captured request id;
  - set drain_q=1 and pulse timeout_evt;
  - go to RSP.
- Watchdog tie-break: a slave response in the expiry cycle wins; no timeout is generated.
- RSP: m[grant_q]_rsp_valid=1 and the other master's rsp_valid=0; fields held stable. On rsp_ready, go to IDLE and set rr_q=~grant_q.
- rr_q changes only on response completion.
- drain_q: s_rsp_ready=1 whenever drain_q=1 in any state. The first s_rsp_valid clears drain_q and the response is discarded.
- drain_q blocks new grants in IDLE.
- Slave contract: the slave sees at most one transaction at a time; ids pass through unchanged. The slave's rsp_id is forwarded as received, not checked.
- Latency, zero-wait slave: master fire at cycle 0, s_req_valid at 1, slave response captured at k, master rsp_valid at k+1.
- Writes and faults: rsp_code passes through unmodified, e.g. a write to ROM returns ACCESS_FAULT to the originating master.
- Reset mid-operation: returns to the reset state immediately and clears drain_q. The slave must be reset concurrently.
- Counter width: tmr is $clog2(TIMEOUT_CYCLES+1) bits, minimum 1, and saturates.

Test Plan:
- m0 read at 0x10 (ROM byte image 0x00..0xFF, latency 1) -> m0_rsp_rdata=0x13121110, code OK, id echoed. m1_rsp_valid stays 0. m0_req_valid→m0_rsp_valid takes 4 cycles.
- m0 and m1 assert continuously with ids 0x1/0x2 -> grants alternate m0,m1,m0,m1. Each response goes to the correct master with its id.
- m1 write, wstrb=0xF -> m1 gets ACCESS_FAULT, rdata=0. rr_q flips to 0.
- TIMEOUT_CYCLES=8, slave never responds -> timeout_evt at WAIT cycle 8, m0 code=0x3, rdata=0. A new m1 request is stalled until a late s_rsp_valid is drained, then it is granted.
- Slave response arrives in the same cycle as expiry -> normal data is delivered, no timeout_evt, drain_q stays 0.
- rst asserted while in REQ and again while in RSP -> next cycle all valids are 0 and state is IDLE. The first post-reset transaction completes normally.
